regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_init_ctrl.sv | 54 +++++
 rtl/regfile_param.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default parameters for the register file
package regfile_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam bit DEF_ZERO_REG = 1'b1;
    localparam bit DEF_BYPASS   = 1'b1;

endpackage

// File: rtl/regfile_init_ctrl.sv
// rtl/regfile_init_ctrl.sv - post-reset clear sweep counter and INIT/READY state machine
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [ADDR_W-1:0] sweep_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        sweep_we      = 1'b0;
        init_busy     = 1'b0;
        case (state)
            INIT: begin
                sweep_we  = 1'b1;
                init_busy = 1'b1;
                if (sweep_cnt == LAST_ADDR) begin
                    state_nxt     = READY;
                    sweep_cnt_nxt = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign sweep_addr = sweep_cnt;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised 2-read/1-write register file with clear sweep and write bypass
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = DEF_ZERO_REG,
    parameter bit BYPASS   = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              init_busy
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    regfile_init_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_busy  (init_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Out-of-range entries and the hardwired zero entry are neither stored nor read.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] a);
        if (!addr_ok(a)) begin
            return '0;
        end else if (BYPASS && user_we && (wr_addr == a)) begin
            return wr_data;
        end else begin
            return mem[a];
        end
    endfunction

    always_comb begin
        user_we   = !init_busy && wr_en && addr_ok(wr_addr);
        mem_we    = rst_n && (sweep_we || user_we);
        mem_waddr = sweep_we ? sweep_addr : wr_addr;
        mem_wdata = sweep_we ? '0 : wr_data;
        rd_next1  = read_entry(rd_addr1);
        rd_next2  = read_entry(rd_addr2);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || init_busy) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
